// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the three memory requesters, the arbiter and the main memory.
// The arbiter attaches through the slave modport; requesters/memory model use master.
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          x_req;
    logic          x_we;
    logic          x_lock;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_wdata;
    logic          x_gnt;
    logic          user_mode;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] rdata;
    logic          if_rvalid;
    logic          d_rvalid;
    logic          x_rvalid;
    logic          fault;
    logic [AW-1:0] fault_addr;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        input  x_req, x_we, x_lock, x_addr, x_wdata, user_mode, mem_rdata,
        output if_gnt, d_gnt, x_gnt, mem_en, mem_we, mem_addr, mem_wdata,
        output rdata, if_rvalid, d_rvalid, x_rvalid, fault, fault_addr
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        output x_req, x_we, x_lock, x_addr, x_wdata, user_mode, mem_rdata,
        input  if_gnt, d_gnt, x_gnt, mem_en, mem_we, mem_addr, mem_wdata,
        input  rdata, if_rvalid, d_rvalid, x_rvalid, fault, fault_addr
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for fetch, data and debug ports: fixed priority with
// fetch anti-starvation, debug bus lock and user-mode protection of the low region.
module mem_port_arbiter #(
    parameter int            AW         = 16,
    parameter int            DW         = 16,
    parameter int            STARVE_MAX = 4,
    parameter logic [AW-1:0] PROT_LIMIT = 16'h0300
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef enum logic {IDLE = 1'b0, XLOCK = 1'b1} state_t;

    state_t        state_reg;
    logic [CW-1:0] starve_cnt_reg;
    logic          if_rvalid_reg;
    logic          d_rvalid_reg;
    logic          x_rvalid_reg;
    logic          fault_reg;
    logic [AW-1:0] fault_addr_reg;
    logic [AW-1:0] addr_hold_reg;
    logic [DW-1:0] wdata_hold_reg;

    logic          starved;
    logic          sel_if;
    logic          sel_d;
    logic          sel_x;
    logic          any_gnt;
    logic          blocked;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    assign starved = (starve_cnt_reg == CW'(STARVE_MAX));

    // Grants are gated by reset so every strobe is low while reset is held.
    always_comb begin
        sel_x  = 1'b0;
        sel_if = 1'b0;
        sel_d  = 1'b0;
        if (reset) begin
            if (state_reg == XLOCK)
                sel_x = bus.x_req;
            else if (bus.x_req)
                sel_x = 1'b1;
            else if (bus.if_req && starved)
                sel_if = 1'b1;
            else if (bus.d_req)
                sel_d = 1'b1;
            else if (bus.if_req)
                sel_if = 1'b1;
        end
    end

    // With no winner the bus keeps showing the last address and write data.
    always_comb begin
        win_addr  = addr_hold_reg;
        win_wdata = wdata_hold_reg;
        win_we    = 1'b0;
        if (sel_x) begin
            win_addr  = bus.x_addr;
            win_wdata = bus.x_wdata;
            win_we    = bus.x_we;
        end else if (sel_d) begin
            win_addr  = bus.d_addr;
            win_wdata = bus.d_wdata;
            win_we    = bus.d_we;
        end else if (sel_if) begin
            win_addr  = bus.if_addr;
        end
    end

    assign any_gnt = sel_x | sel_d | sel_if;
    assign blocked = (sel_if | sel_d) & bus.user_mode & (win_addr < PROT_LIMIT);

    assign bus.if_gnt    = sel_if;
    assign bus.d_gnt     = sel_d;
    assign bus.x_gnt     = sel_x;
    assign bus.mem_en    = any_gnt & ~blocked;
    assign bus.mem_we    = win_we & ~blocked;
    assign bus.mem_addr  = win_addr;
    assign bus.mem_wdata = win_wdata;
    assign bus.rdata     = bus.mem_rdata;
    assign bus.if_rvalid = if_rvalid_reg;
    assign bus.d_rvalid  = d_rvalid_reg;
    assign bus.x_rvalid  = x_rvalid_reg;
    assign bus.fault     = fault_reg;
    assign bus.fault_addr = fault_addr_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= '0;
            if_rvalid_reg  <= 1'b0;
            d_rvalid_reg   <= 1'b0;
            x_rvalid_reg   <= 1'b0;
            fault_reg      <= 1'b0;
            fault_addr_reg <= '0;
            addr_hold_reg  <= '0;
            wdata_hold_reg <= '0;
        end else begin
            case (state_reg)
                IDLE:    if (sel_x && bus.x_lock) state_reg <= XLOCK;
                XLOCK:   if (!bus.x_lock) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase

            // Counts denied fetch cycles, including those spent under the X lock.
            if (bus.if_req && !sel_if) begin
                if (!starved)
                    starve_cnt_reg <= starve_cnt_reg + 1'b1;
            end else begin
                starve_cnt_reg <= '0;
            end

            if_rvalid_reg <= sel_if & ~blocked;
            d_rvalid_reg  <= sel_d & ~bus.d_we & ~blocked;
            x_rvalid_reg  <= sel_x & ~bus.x_we;

            fault_reg <= blocked;
            if (blocked)
                fault_addr_reg <= win_addr;

            addr_hold_reg  <= win_addr;
            wdata_hold_reg <= win_wdata;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios plus randomized requesters, compared each
// cycle against a transaction-level model of the arbitration and memory contents.
module tb_mem_port_arbiter;
    localparam int          AW   = 16;
    localparam int          DW   = 16;
    localparam int          SMAX = 4;
    localparam logic [15:0] PLIM = 16'h0300;

    typedef enum int {P_NONE, P_IF, P_D, P_X} port_e;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .STARVE_MAX(SMAX), .PROT_LIMIT(PLIM)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    // Main memory: 64K x 16 with one-cycle read latency.
    logic [15:0] mem [0:65535];
    logic [15:0] mem_q;
    initial begin
        mem_q = '0;
        for (int i = 0; i < 65536; i++) mem[i] = init_val(16'(i));
    end
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            mem_q <= mem[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = mem_q;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    bit          m_lock;
    int          m_denied;
    port_e       m_rv;
    logic [15:0] m_rv_data;
    bit          m_fault;
    logic [15:0] m_fault_addr;
    logic [15:0] m_last_addr;
    logic [15:0] shadow [int];

    port_e       e_win;
    bit          e_block;
    bit          e_we;
    logic [15:0] e_addr;
    logic [15:0] e_wdata;

    function automatic logic [15:0] shadow_rd(input logic [15:0] a);
        if (shadow.exists(int'(a))) return shadow[int'(a)];
        return init_val(a);
    endfunction

    task automatic model_reset();
        m_lock = 0; m_denied = 0; m_rv = P_NONE; m_fault = 0;
        m_fault_addr = '0; m_last_addr = '0;
    endtask

    task automatic eval_check();
        #1;
        e_win = P_NONE;
        if (reset) begin
            if (m_lock) begin
                if (bus.x_req) e_win = P_X;
            end else if (bus.x_req)                     e_win = P_X;
            else if (bus.if_req && m_denied >= SMAX)    e_win = P_IF;
            else if (bus.d_req)                         e_win = P_D;
            else if (bus.if_req)                        e_win = P_IF;
        end
        e_we = 0; e_addr = m_last_addr; e_wdata = '0;
        case (e_win)
            P_X:  begin e_addr = bus.x_addr; e_we = bus.x_we; e_wdata = bus.x_wdata; end
            P_D:  begin e_addr = bus.d_addr; e_we = bus.d_we; e_wdata = bus.d_wdata; end
            P_IF: e_addr = bus.if_addr;
            default: ;
        endcase
        e_block = (e_win == P_IF || e_win == P_D) && bus.user_mode && (e_addr < PLIM);
        if (e_win != P_NONE)
            $display("txn t=%0t port=%s addr=%h we=%0d blocked=%0d", $time, e_win.name(), e_addr, e_we, e_block);

        check_val("if_gnt", bus.if_gnt, e_win == P_IF);
        check_val("d_gnt", bus.d_gnt, e_win == P_D);
        check_val("x_gnt", bus.x_gnt, e_win == P_X);
        check_val("mem_en", bus.mem_en, e_win != P_NONE && !e_block);
        check_val("mem_we", bus.mem_we, e_we && !e_block);
        check_val("mem_addr", bus.mem_addr, e_addr);
        if (e_we && !e_block) check_val("mem_wdata", bus.mem_wdata, e_wdata);
        check_val("if_rvalid", bus.if_rvalid, m_rv == P_IF);
        check_val("d_rvalid", bus.d_rvalid, m_rv == P_D);
        check_val("x_rvalid", bus.x_rvalid, m_rv == P_X);
        if (m_rv != P_NONE) check_val("rdata", bus.rdata, m_rv_data);
        check_val("fault", bus.fault, m_fault);
        check_val("fault_addr", bus.fault_addr, m_fault_addr);
    endtask

    task automatic clock_edge();
        @(posedge clk);
        if (bus.if_req && e_win != P_IF) m_denied = (m_denied < SMAX) ? m_denied + 1 : SMAX;
        else                             m_denied = 0;
        if (m_lock) m_lock = bus.x_lock;
        else        m_lock = (e_win == P_X) && bus.x_lock;
        m_rv = (e_win != P_NONE && !e_we && !e_block) ? e_win : P_NONE;
        if (m_rv != P_NONE) m_rv_data = shadow_rd(e_addr);
        if (e_win != P_NONE && e_we && !e_block) shadow[int'(e_addr)] = e_wdata;
        m_fault = e_block;
        if (e_block) m_fault_addr = e_addr;
        if (e_win != P_NONE) m_last_addr = e_addr;
        #1;
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b0;
        #1;
        model_reset();
        check_val("rst_gnt", {bus.if_gnt, bus.d_gnt, bus.x_gnt}, 0);
        check_val("rst_mem", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
        check_val("rst_rv", {bus.if_rvalid, bus.d_rvalid, bus.x_rvalid, bus.fault}, 0);
        check_val("rst_faddr", bus.fault_addr, 0);
        repeat (cycles) @(posedge clk);
        #1;
        check_val("rst_hold", {bus.if_rvalid, bus.d_rvalid, bus.x_rvalid, bus.fault}, 0);
        reset = 1'b1;
    endtask

    function automatic logic [15:0] gen_addr();
        case ($urandom_range(0, 3))
            0:       return 16'h02F8 + 16'($urandom_range(0, 15));
            1:       return ($urandom_range(0, 1) != 0) ? 16'h02FF : 16'h0300;
            2:       return 16'h0300 + 16'($urandom_range(0, 7));
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic idle_inputs();
        bus.if_req = 0; bus.d_req = 0; bus.x_req = 0; bus.x_lock = 0;
        bus.d_we = 0; bus.x_we = 0;
    endtask

    int pat_bad;

    initial begin
        idle_inputs();
        bus.if_addr = 16'h0310; bus.d_addr = 16'h0400; bus.x_addr = 16'h0000;
        bus.d_wdata = '0; bus.x_wdata = '0; bus.user_mode = 0;

        // Reset with every port requesting, then release into fetch-vs-data contention
        bus.if_req = 1; bus.d_req = 1; bus.x_req = 1; bus.x_lock = 1;
        apply_reset(3);
        bus.x_req = 0; bus.x_lock = 0;
        for (int i = 0; i < 10; i++) begin
            eval_check();
            if (i == 0) begin
                check_val("rst_prio_d", bus.d_gnt, 1);
                check_val("rst_prio_addr", bus.mem_addr, 16'h0400);
            end
            pat_bad = (i % 5 == 4) ? 2 : 1;
            check_val("starve_pat", {bus.if_gnt, bus.d_gnt}, pat_bad);
            clock_edge();
        end

        // Debug write then data read of the same word
        idle_inputs();
        bus.x_req = 1; bus.x_we = 1; bus.x_addr = 16'h0305; bus.x_wdata = 16'hBEEF;
        eval_check(); clock_edge();
        idle_inputs();
        bus.d_req = 1; bus.d_addr = 16'h0305;
        eval_check(); clock_edge();
        idle_inputs();
        eval_check();
        check_val("rd_dvalid", bus.d_rvalid, 1);
        check_val("rd_data", bus.rdata, 16'hBEEF);
        check_val("rd_others", {bus.if_rvalid, bus.x_rvalid}, 0);
        clock_edge();

        // Locked debug burst against competing fetch and data requests
        bus.if_req = 1; bus.d_req = 1; bus.d_addr = 16'h0400;
        for (int k = 0; k < 3; k++) begin
            bus.x_req = 1; bus.x_lock = 1; bus.x_we = 1;
            bus.x_addr = 16'(k); bus.x_wdata = 16'h1000 + 16'(k);
            eval_check();
            check_val("lock_xgnt", {bus.x_gnt, bus.d_gnt, bus.if_gnt}, 3'b100);
            check_val("lock_we", bus.mem_we, 1);
            clock_edge();
        end
        bus.x_req = 0; bus.x_lock = 0; bus.x_we = 0;
        eval_check(); clock_edge();
        bus.if_req = 0;
        eval_check();
        check_val("lock_rel_d", bus.d_gnt, 1);
        clock_edge();

        // User-mode protection at and just below the limit
        idle_inputs();
        bus.user_mode = 1; bus.d_req = 1; bus.d_we = 1;
        bus.d_addr = 16'h02FF; bus.d_wdata = 16'h1234;
        eval_check();
        check_val("prot_gnt", bus.d_gnt, 1);
        check_val("prot_en", bus.mem_en, 0);
        clock_edge();
        bus.d_addr = 16'h0300; bus.d_wdata = 16'h5678;
        eval_check();
        check_val("prot_fault", bus.fault, 1);
        check_val("prot_faddr", bus.fault_addr, 16'h02FF);
        check_val("legal_en", {bus.mem_en, bus.mem_we}, 2'b11);
        clock_edge();
        idle_inputs();
        eval_check();
        check_val("legal_nofault", bus.fault, 0);
        clock_edge();
        bus.x_req = 1; bus.x_addr = 16'h02FF;
        eval_check(); clock_edge();
        idle_inputs();
        eval_check();
        check_val("prot_unchanged", bus.rdata, 16'h02FF ^ 16'hA5C3);
        clock_edge();

        // Reset arrives while a fetch read is in flight
        bus.user_mode = 0; bus.if_req = 1; bus.if_addr = 16'h0310;
        eval_check();
        check_val("midrst_ifgnt", bus.if_gnt, 1);
        @(negedge clk);
        apply_reset(2);
        bus.d_req = 1;
        for (int i = 0; i < 5; i++) begin
            eval_check();
            check_val("midrst_pat", {bus.if_gnt, bus.d_gnt}, (i == 4) ? 2 : 1);
            clock_edge();
        end

        // Randomized requesters that hold each request until granted
        idle_inputs();
        for (int c = 0; c < 1500; c++) begin
            eval_check();
            clock_edge();
            if (!bus.if_req || e_win == P_IF) begin
                bus.if_req = ($urandom_range(0, 99) < 60);
                bus.if_addr = gen_addr();
            end
            if (!bus.d_req || e_win == P_D) begin
                bus.d_req = ($urandom_range(0, 99) < 50);
                bus.d_we = ($urandom_range(0, 1) != 0);
                bus.d_addr = gen_addr();
                bus.d_wdata = 16'($urandom);
            end
            if (!bus.x_req || e_win == P_X) begin
                bus.x_req = ($urandom_range(0, 99) < 20);
                bus.x_we = ($urandom_range(0, 1) != 0);
                bus.x_addr = gen_addr();
                bus.x_wdata = 16'($urandom);
            end
            bus.x_lock = m_lock ? ($urandom_range(0, 99) < 75) : ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 99) < 5) bus.user_mode = ~bus.user_mode;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port main memory (64K x 16, one-cycle read latency) among three requesters.
- Requesters: instruction fetch (IF), load/store data (D) and the debug/loader port (X).
- Sits between the RiSC core and MEM; all memory traffic passes through it.
- Provides fixed priority with fetch anti-starvation, an X-port bus lock for bursts, and user-mode protection of the system region below PROT_LIMIT.

Parameters:
- AW, 16, address width
- DW, 16, data width
- STARVE_MAX, 4, consecutive denied IF-request cycles before IF is promoted
- PROT_LIMIT, 16'h0300, first user-accessible address; user accesses below it fault

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 = reset asserted
- if_req  in  1  fetch request (read only)
- if_addr  in  AW  fetch address
- if_gnt  out  1  fetch granted this cycle
- d_req  in  1  data request
- d_we  in  1  1 = store
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_gnt  out  1  data granted this cycle
- x_req  in  1  debug request
- x_we  in  1  1 = write
- x_lock  in  1  hold the bus for X after its grant
- x_addr  in  AW  debug address
- x_wdata  in  DW  debug write data
- x_gnt  out  1  debug granted this cycle
- user_mode  in  1  core privilege; 1 = user
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid the cycle after mem_en with mem_we=0
- rdata  out  DW  read data, equal to mem_rdata
- if_rvalid  out  1  rdata belongs to IF, registered
- d_rvalid  out  1  rdata belongs to D, registered
- x_rvalid  out  1  rdata belongs to X, registered
- fault  out  1  one-cycle pulse: protection violation
- fault_addr  out  AW  address of the last faulting access

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; starve_cnt=0.
  - All gnt, rvalid, fault and mem_* outputs are 0; fault_addr=0.
- Grant decision is combinational each cycle; exactly one gnt or none. Requesters hold req, addr and data until they see gnt high in the same cycle.
- Priority in IDLE, highest first:
  1. X
  2. IF, if starve_cnt==STARVE_MAX
  3. D
  4. IF
- FSM:
  - IDLE -> XLOCK when X is granted with x_lock=1.
  - In XLOCK only X may be granted; IF and D see gnt=0.
  - XLOCK -> IDLE on the first edge where x_lock=0, regardless of x_req.
- starve_cnt:
  - Increments on each edge where if_req=1 and if_gnt=0, saturating at STARVE_MAX.
  - Clears on if_gnt=1 or if_req=0.
  - Also increments during XLOCK.
- Memory drive on the granted port:
  - mem_en=1; mem_addr, mem_wdata and mem_we come from the winner. IF drives mem_we=0.
  - No grant: mem_en=0, mem_we=0; mem_addr and mem_wdata are don't-care but must hold their previous value.
- Read return:
  - A granted, non-blocked read sets the winner's rvalid for exactly one cycle, on the next edge.
  - rdata = mem_rdata combinationally.
  - Back-to-back reads from different ports give back-to-back rvalids, in grant order.
- Protection:
  - An IF or D access with user_mode=1 and addr < PROT_LIMIT is still granted, so the requester retires it.
  - mem_en and mem_we are forced to 0 for that access, and no rvalid is produced.
  - On the next edge fault=1 for one cycle and fault_addr latches the address.
  - X is never checked. addr == PROT_LIMIT is legal.
- Simultaneous requests: the loser holds its request; it is served when it wins later with no loss or duplication.
- Reset mid-operation: pending rvalid and fault are dropped; XLOCK exits.

Test Plan:
- Reset priority:
  - Stimulus: reset=0 while all reqs=1.
  - Required: all outputs 0.
  - Stimulus: release reset with if_req=d_req=1, user_mode=0.
  - Required: d_gnt=1, mem_addr=d_addr.
- Fetch anti-starvation:
  - Stimulus: if_req=1, d_req=1 held continuously, d_addr=16'h0400, if_addr=16'h0310.
  - Required: d_gnt for 4 cycles, then if_gnt for 1 cycle, then D again; repeating 4:1 pattern.
- Read return:
  - Stimulus: D read of 16'h0305 where MEM holds 16'hBEEF.
  - Required: next cycle d_rvalid=1, rdata=16'hBEEF, if_rvalid=x_rvalid=0.
- X lock:
  - Stimulus: x_req=1, x_lock=1 for 3 cycles writing 16'h0000..16'h0002 while IF and D request.
  - Required: only x_gnt for those 3 cycles; mem_we=1 each cycle.
  - Stimulus: drop x_lock.
  - Required: D granted on the following cycle.
- Protection:
  - Stimulus: user_mode=1, D store to 16'h02FF.
  - Required: d_gnt=1, mem_en=0; next cycle fault=1, fault_addr=16'h02FF, memory unchanged.
  - Stimulus: same store to 16'h0300.
  - Required: write occurs, no fault.
- Mid-read reset:
  - Stimulus: assert reset one cycle after an IF grant.
  - Required: if_rvalid stays 0; FSM IDLE; starve_cnt 0.
